// File: rtl/mux_wd_pipe_if.sv
// Purpose: handshake bundle for mux_wd_pipe (input select/data side and output queue side).
// Signals:
//   in_valid/in_ready   - producer handshake; transfer when both high
//   sel/data_in         - binary source selector and flat source bus
//   out_valid/out_ready - consumer handshake; pop when both high
//   out_data/occupancy  - head-of-queue word and number of held entries
//   sel_err             - sticky out-of-range flag, only with MUX_WD_SEL_CHECK_EN
// master: the environment side; slave: the selector block.
interface mux_wd_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NUM_IN = 6,
  parameter int unsigned SEL_W  = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         sel;
  logic [NUM_IN*DATA_W-1:0] data_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic [1:0]               occupancy;
`ifdef MUX_WD_SEL_CHECK_EN
  logic                     sel_err;

  modport master (
    output in_valid, sel, data_in, out_ready,
    input  in_ready, out_valid, out_data, occupancy, sel_err
  );
  modport slave (
    input  in_valid, sel, data_in, out_ready,
    output in_ready, out_valid, out_data, occupancy, sel_err
  );
`else
  modport master (
    output in_valid, sel, data_in, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
  modport slave (
    input  in_valid, sel, data_in, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
`endif
endinterface

// File: rtl/mux_wd_pipe.sv
// Purpose: register-file write-data source selector with a 2-entry skid queue.
//   sel==0 or sel>NUM_IN selects CONST_VAL; sel==k (1..NUM_IN) selects source k.
//   The selected word is captured at the push edge and emitted in FIFO order.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - mux_wd_pipe_if.slave (in/out handshakes, sel, data_in, out_data, occupancy)
// Optional feature: define MUX_WD_SEL_CHECK_EN to add the sticky bus.sel_err flag.
module mux_wd_pipe #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NUM_IN    = 6,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned CONST_VAL = 227
) (
  input  logic          clk,
  input  logic          reset,
  mux_wd_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] sel_word_c;
  logic              push_c;
  logic              pop_c;

  // Source selection; anything not matching a real source falls back to the constant.
  always_comb begin : sel_mux
    sel_word_c = DATA_W'(CONST_VAL);
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.sel == SEL_W'(k + 1)) begin
        sel_word_c = bus.data_in[k*DATA_W +: DATA_W];
      end
    end
  end

  assign push_c = bus.in_valid && in_ready_q;
  assign pop_c  = out_valid_q && bus.out_ready;

  // Queue state register.
  always_ff @(posedge clk or posedge reset) begin : state_reg
    if (reset) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state: head keeps its value on the final pop so out_data holds the last word.
  always_comb begin : next_state
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_c) begin
          head_d  = sel_word_c;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push_c && pop_c) begin
          head_d = sel_word_c;
        end else if (push_c) begin
          tail_d  = sel_word_c;
          state_d = ST_FULL;
        end else if (pop_c) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop_c) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Handshake flags are registered from the next state, so in_ready never sees out_ready.
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_FULL);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = head_q;
  assign bus.occupancy = 2'(state_q);

`ifdef MUX_WD_SEL_CHECK_EN
  logic sel_err_q;

  // Sticky flag for a push that carried a selector beyond the last source.
  always_ff @(posedge clk or posedge reset) begin : sel_err_reg
    if (reset) begin
      sel_err_q <= 1'b0;
    end else if (push_c && (32'(bus.sel) > NUM_IN)) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`endif

endmodule
